// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle controller and its datapath.
// The controller drives every datapath control; the datapath supplies run and the IR fields.
interface multicycle_control_if;
  logic        run;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        PCWrite;
  logic        PCWriteCond;
  logic        IorD;
  logic        MemRead;
  logic        MemWrite;
  logic        IRWrite;
  logic        MemtoReg;
  logic        ALUSrcA;
  logic        RegWrite;
  logic        RegDst;
  logic [1:0]  PCSource;
  logic [3:0]  ALUOp;
  logic [1:0]  ALUSrcB;
  logic [3:0]  state;
  logic        illegal;
  logic [31:0] instr_count;

  modport master (
    input  run, opcode, funct,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB,
           state, illegal, instr_count
  );

  modport slave (
    output run, opcode, funct,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB,
           state, illegal, instr_count
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore FSM sequencing the multicycle datapath, with run gating, a sticky
// illegal-opcode flag and a retired-instruction counter.
module multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [3:0] ALU_ADD  = 4'b0010,
  parameter logic [3:0] ALU_SUB  = 4'b0110
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] pc_source;
    logic [3:0] alu_op;
    logic [1:0] alu_src_b;
  } ctrl_t;

  state_t      state_r;
  state_t      next_state_s;
  state_t      end_state_s;
  ctrl_t       ctrl_r;
  logic        illegal_r;
  logic        illegal_set_s;
  logic        retire_s;
  logic [31:0] instr_count_r;
  logic [3:0]  alu_op_s;

  // Control word for a state; EXEC's ALUOp comes from funct outside this table.
  function automatic ctrl_t decode_ctrl(input state_t st);
    ctrl_t c;
    c = '0;
    case (st)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = 2'b01;
        c.alu_op    = ALU_ADD;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        c.alu_op    = ALU_ADD;
      end
      S_MEMADR, S_IEXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.ior_d    = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.ior_d     = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
      end
      S_RWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_IWB: begin
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Where an instruction goes when it ends: straight into the next fetch or back to idle.
  always_comb begin
    end_state_s = S_IDLE;
    if (bus.run) begin
      end_state_s = S_FETCH;
    end else begin
      end_state_s = S_IDLE;
    end
  end

  // Next-state selection plus the retire and illegal-opcode events of this edge.
  always_comb begin
    next_state_s  = S_IDLE;
    illegal_set_s = 1'b0;
    retire_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.run) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_FETCH: next_state_s = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: next_state_s = S_MEMADR;
          OP_RTYPE:     next_state_s = S_EXEC;
          OP_ADDI:      next_state_s = S_IEXEC;
          OP_BEQ:       next_state_s = S_BRANCH;
          OP_J:         next_state_s = S_JUMP;
          default: begin
            next_state_s  = end_state_s;
            illegal_set_s = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        if (bus.opcode == OP_LW) begin
          next_state_s = S_MEMRD;
        end else begin
          next_state_s = S_MEMWR;
        end
      end
      S_MEMRD: next_state_s = S_MEMWB;
      S_EXEC:  next_state_s = S_RWB;
      S_IEXEC: next_state_s = S_IWB;
      S_MEMWB, S_MEMWR, S_RWB, S_IWB, S_BRANCH, S_JUMP: begin
        next_state_s = end_state_s;
        retire_s     = 1'b1;
      end
      default: next_state_s = S_IDLE;
    endcase
  end

  // State register; the control word is registered alongside it from the same next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= S_IDLE;
      ctrl_r  <= '0;
    end else begin
      state_r <= next_state_s;
      ctrl_r  <= decode_ctrl(next_state_s);
    end
  end

  // Sticky illegal flag: only reset clears it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      illegal_r <= 1'b0;
    end else if (illegal_set_s) begin
      illegal_r <= 1'b1;
    end
  end

  // Retired-instruction counter, free-running wrap at 2^32.
  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_count_r <= 32'd0;
    end else if (retire_s) begin
      instr_count_r <= instr_count_r + 32'd1;
    end
  end

  // EXEC hands funct straight to the ALU; every other state uses the registered code.
  always_comb begin
    alu_op_s = 4'd0;
    if (state_r == S_EXEC) begin
      alu_op_s = bus.funct[3:0];
    end else begin
      alu_op_s = ctrl_r.alu_op;
    end
  end

  assign bus.PCWrite     = ctrl_r.pc_write;
  assign bus.PCWriteCond = ctrl_r.pc_write_cond;
  assign bus.IorD        = ctrl_r.ior_d;
  assign bus.MemRead     = ctrl_r.mem_read;
  assign bus.MemWrite    = ctrl_r.mem_write;
  assign bus.IRWrite     = ctrl_r.ir_write;
  assign bus.MemtoReg    = ctrl_r.mem_to_reg;
  assign bus.ALUSrcA     = ctrl_r.alu_src_a;
  assign bus.RegWrite    = ctrl_r.reg_write;
  assign bus.RegDst      = ctrl_r.reg_dst;
  assign bus.PCSource    = ctrl_r.pc_source;
  assign bus.ALUSrcB     = ctrl_r.alu_src_b;
  assign bus.ALUOp       = alu_op_s;
  assign bus.state       = state_r;
  assign bus.illegal     = illegal_r;
  assign bus.instr_count = instr_count_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed instruction walk with literal expectations,
// then randomized run/opcode/reset traffic checked every cycle against an instruction-path model.
module tb_multicycle_control;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  bit   checking;

  multicycle_control_if bus();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Expected control word for a state, straight from the per-state control list.
  function automatic logic [17:0] exp_ctrl(input int st, input logic [5:0] f);
    logic pw, pwc, iord, mr, mw, irw, m2r, asa, rw, rd;
    logic [1:0] pcs, asb;
    logic [3:0] aop;
    {pw, pwc, iord, mr, mw, irw, m2r, asa, rw, rd} = 10'd0;
    pcs = 2'b00; asb = 2'b00; aop = 4'd0;
    case (st)
      1:  begin mr = 1'b1; irw = 1'b1; pw = 1'b1; asb = 2'b01; aop = ALU_ADD; end
      2:  begin asb = 2'b11; aop = ALU_ADD; end
      3:  begin asa = 1'b1; asb = 2'b10; aop = ALU_ADD; end
      4:  begin mr = 1'b1; iord = 1'b1; end
      5:  begin rw = 1'b1; m2r = 1'b1; end
      6:  begin mw = 1'b1; iord = 1'b1; end
      7:  begin asa = 1'b1; aop = f[3:0]; end
      8:  begin rw = 1'b1; rd = 1'b1; end
      9:  begin asa = 1'b1; asb = 2'b10; aop = ALU_ADD; end
      10: begin rw = 1'b1; end
      11: begin asa = 1'b1; aop = ALU_SUB; pwc = 1'b1; pcs = 2'b01; end
      12: begin pw = 1'b1; pcs = 2'b10; end
      default: ;
    endcase
    return {pw, pwc, iord, mr, mw, irw, m2r, asa, rw, rd, pcs, aop, asb};
  endfunction

  logic [17:0] dut_ctrl;
  assign dut_ctrl = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                     bus.IRWrite, bus.MemtoReg, bus.ALUSrcA, bus.RegWrite, bus.RegDst,
                     bus.PCSource, bus.ALUOp, bus.ALUSrcB};

  // Model: an instruction is FETCH, DECODE, then a fixed path chosen by opcode.
  int          m_state;
  int          m_rest[$];
  bit          m_ill;
  logic [31:0] m_cnt;

  always @(posedge clk) begin
    if (!reset) begin
      m_state = 0;
      m_rest.delete();
      m_ill = 1'b0;
      m_cnt = 32'd0;
    end else if (m_state == 0) begin
      m_state = bus.run ? 1 : 0;
    end else if (m_state == 1) begin
      m_state = 2;
    end else if (m_state == 2) begin
      case (bus.opcode)
        OP_LW:    m_rest = '{3, 4, 5};
        OP_SW:    m_rest = '{3, 6};
        OP_RTYPE: m_rest = '{7, 8};
        OP_ADDI:  m_rest = '{9, 10};
        OP_BEQ:   m_rest = '{11};
        OP_J:     m_rest = '{12};
        default:  m_rest.delete();
      endcase
      if (m_rest.size() == 0) begin
        m_ill = 1'b1;
        m_state = bus.run ? 1 : 0;
      end else begin
        m_state = m_rest.pop_front();
      end
    end else if (m_rest.size() > 0) begin
      m_state = m_rest.pop_front();
    end else begin
      m_cnt = m_cnt + 32'd1;
      m_state = bus.run ? 1 : 0;
    end
  end

  // Every-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    if (checking) begin
      chk("model_state", {28'd0, bus.state}, m_state);
      chk("model_ctrl", {14'd0, dut_ctrl}, {14'd0, exp_ctrl(m_state, bus.funct)});
      chk("model_illegal", {31'd0, bus.illegal}, {31'd0, m_ill});
      chk("model_count", bus.instr_count, m_cnt);
      if (bus.MemRead && bus.MemWrite) chk("memrd_memwr_excl", 32'd1, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic step_state(input string name, input int st);
    tick();
    chk(name, {28'd0, bus.state}, st);
  endtask

  logic [5:0] pick;

  initial begin
    errors = 0;
    checks = 0;
    checking = 1'b0;
    reset = 1'b0;
    bus.run = 1'b0;
    bus.opcode = 6'd0;
    bus.funct = 6'd0;
    tick();
    checking = 1'b1;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_state", {28'd0, bus.state}, 32'd0);
      chk("idle_ctrl", {14'd0, dut_ctrl}, 32'd0);
      chk("idle_count", bus.instr_count, 32'd0);
      chk("idle_illegal", {31'd0, bus.illegal}, 32'd0);
    end

    // LW: 1,2,3,4,5 then the next fetch
    bus.run = 1'b1;
    bus.opcode = OP_LW;
    step_state("lw_s1", 1);
    step_state("lw_s2", 2);
    step_state("lw_s3", 3);
    step_state("lw_s4", 4);
    chk("lw_s4_memread", {31'd0, bus.MemRead}, 32'd1);
    chk("lw_s4_iord", {31'd0, bus.IorD}, 32'd1);
    step_state("lw_s5", 5);
    chk("lw_s5_regwrite", {31'd0, bus.RegWrite}, 32'd1);
    chk("lw_s5_memtoreg", {31'd0, bus.MemtoReg}, 32'd1);
    step_state("lw_next", 1);
    chk("lw_count", bus.instr_count, 32'd1);

    // R-type with funct 100010 -> ALUOp 0010 in EXEC
    bus.opcode = OP_RTYPE;
    bus.funct = 6'b100010;
    step_state("r_s2", 2);
    step_state("r_s7", 7);
    chk("r_aluop", {28'd0, bus.ALUOp}, 32'h2);
    step_state("r_s8", 8);
    chk("r_regdst", {31'd0, bus.RegDst}, 32'd1);
    chk("r_regwrite", {31'd0, bus.RegWrite}, 32'd1);
    step_state("r_next", 1);
    chk("r_count", bus.instr_count, 32'd2);

    bus.opcode = OP_BEQ;
    step_state("beq_s2", 2);
    step_state("beq_s11", 11);
    chk("beq_pcwc", {31'd0, bus.PCWriteCond}, 32'd1);
    chk("beq_pcsrc", {30'd0, bus.PCSource}, 32'd1);
    chk("beq_aluop", {28'd0, bus.ALUOp}, 32'h6);
    step_state("beq_next", 1);
    chk("beq_count", bus.instr_count, 32'd3);

    bus.opcode = OP_J;
    step_state("j_s2", 2);
    step_state("j_s12", 12);
    chk("j_pcwrite", {31'd0, bus.PCWrite}, 32'd1);
    chk("j_pcsrc", {30'd0, bus.PCSource}, 32'd2);
    step_state("j_next", 1);
    chk("j_count", bus.instr_count, 32'd4);

    bus.opcode = 6'b111111;
    step_state("ill_s2", 2);
    step_state("ill_next", 1);
    chk("ill_flag", {31'd0, bus.illegal}, 32'd1);
    chk("ill_count", bus.instr_count, 32'd4);

    // SW with run dropped mid-instruction still completes, then idles
    bus.opcode = OP_SW;
    step_state("sw_s2", 2);
    bus.run = 1'b0;
    step_state("sw_s3", 3);
    step_state("sw_s6", 6);
    chk("sw_memwrite", {31'd0, bus.MemWrite}, 32'd1);
    step_state("sw_idle", 0);
    chk("sw_count", bus.instr_count, 32'd5);
    chk("ill_sticky", {31'd0, bus.illegal}, 32'd1);
    step_state("sw_idle2", 0);

    // Reset in the middle of an LW at MEMRD
    bus.run = 1'b1;
    bus.opcode = OP_LW;
    step_state("rst_s1", 1);
    step_state("rst_s2", 2);
    step_state("rst_s3", 3);
    step_state("rst_s4", 4);
    reset = 1'b0;
    step_state("rst_state", 0);
    chk("rst_ctrl", {14'd0, dut_ctrl}, 32'd0);
    chk("rst_count", bus.instr_count, 32'd0);
    chk("rst_illegal", {31'd0, bus.illegal}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      bus.run = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 79) != 0);
      if (m_state <= 1) begin
        case ($urandom_range(0, 7))
          0: pick = OP_RTYPE;
          1: pick = OP_LW;
          2: pick = OP_SW;
          3: pick = OP_BEQ;
          4: pick = OP_J;
          5: pick = OP_ADDI;
          default: pick = 6'($urandom_range(0, 63));
        endcase
        bus.opcode = pick;
      end
      bus.funct = 6'($urandom_range(0, 63));
      tick();
    end

    checking = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
